// File: rtl/time_strobe_gen_pkg.sv
// Shared timing definitions for the time-synchronisation strobe link.
// The downstream receiver imports the same NS_PER_SEC so both ends roll seconds identically.
package time_strobe_gen_pkg;

   localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COMP,
      ST_SETUP,
      ST_WAIT_PPS,
      ST_STROBE,
      ST_HOLD
   } tsg_state_e;

   typedef struct packed {
      logic [31:0] sec;
      logic [31:0] ns;
   } tstamp_t;

   // The PPS edge reaches the FSM two cycles after it is registered: sync stage plus edge register.
   function automatic logic [31:0] pps_lat_ns(input int unsigned clk_period_ns);
      return 32'(2 * clk_period_ns);
   endfunction

   // Adds a latency offset to a timestamp, carrying into seconds with 32-bit wrap.
   function automatic tstamp_t apply_comp(input logic [31:0] sec,
                                          input logic [31:0] base_ns,
                                          input logic [31:0] comp_ns);
      logic [32:0] sum;
      tstamp_t     t;
      sum = {1'b0, base_ns} + {1'b0, comp_ns};
      if (sum >= {1'b0, NS_PER_SEC}) begin
         t.sec = sec + 32'd1;
         t.ns  = 32'(sum - {1'b0, NS_PER_SEC});
      end else begin
         t.sec = sec;
         t.ns  = 32'(sum);
      end
      return t;
   endfunction

endpackage

// File: rtl/time_strobe_gen_if.sv
// Time-set request channel: seconds/nanoseconds plus PPS-alignment flag on a valid/ready handshake.
interface time_strobe_gen_if;

   logic [31:0] s_sec;
   logic [31:0] s_ns;
   logic        s_at_pps;
   logic        s_valid;
   logic        s_ready;

   modport master (output s_sec, output s_ns, output s_at_pps, output s_valid, input s_ready);
   modport slave  (input s_sec, input s_ns, input s_at_pps, input s_valid, output s_ready);

endinterface

// File: rtl/time_strobe_gen_pps_edge_sync.sv
// Three-flop synchroniser for an asynchronous PPS input followed by a registered
// rising-edge pulse; usable by any PPS consumer in the aclk domain.
module pps_edge_sync (
   input  logic aclk,
   input  logic aresetn,
   input  logic pps_in,
   output logic pps_rise
);

   (* ASYNC_REG = "TRUE" *) logic [2:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sync_q   <= '0;
         pps_rise <= 1'b0;
      end else begin
         sync_q   <= {sync_q[1:0], pps_in};
         pps_rise <= sync_q[1] & ~sync_q[2];
      end
   end

endmodule

// File: rtl/time_strobe_gen.sv
// Time-strobe transmitter: registers a time-set request, adds latency compensation and
// drives sec/ns with a framed strobe, either immediately or aligned to the next PPS edge.
module time_strobe_gen
   import time_strobe_gen_pkg::*;
#(
   parameter int unsigned CLK_PERIOD_NS      = 10,
   parameter int unsigned COMP_NS            = 30,
   parameter int unsigned SETUP_CYCLES       = 4,
   parameter int unsigned STROBE_CYCLES      = 4,
   parameter int unsigned HOLD_CYCLES        = 4,
   parameter int unsigned PPS_TIMEOUT_CYCLES = 200_000_000
) (
   input  logic               aclk,
   input  logic               aresetn,
   time_strobe_gen_if.slave   req,
   input  logic               pps_in,
   output logic [31:0]        time_strobe_sec,
   output logic [31:0]        time_strobe_ns,
   output logic               time_strobe,
   output logic               busy,
   output logic               done,
   output logic               err_range,
   output logic               err_timeout
);

   localparam logic [7:0]  SETUP_LD  = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0]  STROBE_LD = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0]  HOLD_LD   = 8'(HOLD_CYCLES - 1);
   localparam logic [31:0] TMO_LAST  = 32'(PPS_TIMEOUT_CYCLES - 1);
   localparam logic [31:0] PPS_LAT   = pps_lat_ns(CLK_PERIOD_NS);

   tsg_state_e  state_q, state_d;
   logic [7:0]  phase_q, phase_d;
   logic [31:0] tmo_q, tmo_d;
   logic        ready_q;
   logic        accept, capture, load_out, range_bad, tmo_hit;
   logic [31:0] sec_q, ns_q;
   logic        at_pps_q;
   logic        pps_rise;
   tstamp_t     comp_t;

   pps_edge_sync u_pps_sync (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .pps_in   (pps_in),
      .pps_rise (pps_rise)
   );

   assign accept      = req.s_valid & ready_q & (state_q == ST_IDLE);
   assign req.s_ready = ready_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_HOLD) && (phase_q == 8'd0);

   always_comb begin
      comp_t = apply_comp(sec_q, at_pps_q ? PPS_LAT : ns_q, 32'(COMP_NS));
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d   = state_q;
      phase_d   = phase_q;
      tmo_d     = tmo_q;
      capture   = 1'b0;
      load_out  = 1'b0;
      range_bad = 1'b0;
      tmo_hit   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!req.s_at_pps && (req.s_ns >= NS_PER_SEC)) begin
                  range_bad = 1'b1;
               end else begin
                  capture = 1'b1;
                  state_d = ST_COMP;
               end
            end
         end
         ST_COMP: begin
            load_out = 1'b1;
            if (at_pps_q) begin
               state_d = ST_WAIT_PPS;
               tmo_d   = '0;
            end else begin
               state_d = ST_SETUP;
               phase_d = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (phase_q == 8'd0) begin
               state_d = ST_STROBE;
               phase_d = STROBE_LD;
            end else begin
               phase_d = phase_q - 8'd1;
            end
         end
         ST_WAIT_PPS: begin
            // Edge is tested first so a PPS arriving on the timeout cycle still strobes.
            if (pps_rise) begin
               state_d = ST_STROBE;
               phase_d = STROBE_LD;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_IDLE;
               tmo_hit = 1'b1;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         ST_STROBE: begin
            if (phase_q == 8'd0) begin
               state_d = ST_HOLD;
               phase_d = HOLD_LD;
            end else begin
               phase_d = phase_q - 8'd1;
            end
         end
         ST_HOLD: begin
            if (phase_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               phase_d = phase_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         tmo_q       <= '0;
         ready_q     <= 1'b0;
         time_strobe <= 1'b0;
         err_range   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         tmo_q       <= tmo_d;
         ready_q     <= (state_d == ST_IDLE);
         time_strobe <= (state_d == ST_STROBE);
         err_range   <= range_bad;
         err_timeout <= tmo_hit;
      end
   end

   // NOTE: data registers are reset too, because the outputs must read zero while aresetn is low.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sec_q           <= '0;
         ns_q            <= '0;
         at_pps_q        <= 1'b0;
         time_strobe_sec <= '0;
         time_strobe_ns  <= '0;
      end else begin
         if (capture) begin
            sec_q    <= req.s_sec;
            ns_q     <= req.s_ns;
            at_pps_q <= req.s_at_pps;
         end
         // Outputs change only here, so they are frozen through SETUP, STROBE and HOLD.
         if (load_out) begin
            time_strobe_sec <= comp_t.sec;
            time_strobe_ns  <= comp_t.ns;
         end
      end
   end

endmodule

// File: tb/tb_time_strobe_gen.sv
// Directed bench for time_strobe_gen: immediate, carry/wrap, range reject, PPS-aligned,
// timeout, edge/timeout collision and asynchronous reset during the strobe.
module tb_time_strobe_gen;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        pps_in = 1'b0;
   logic [31:0] time_strobe_sec, time_strobe_ns;
   logic        time_strobe, busy, done, err_range, err_timeout;

   int checks   = 0;
   int failures = 0;

   time_strobe_gen_if bus ();

   time_strobe_gen #(
      .CLK_PERIOD_NS      (10),
      .COMP_NS            (30),
      .SETUP_CYCLES       (4),
      .STROBE_CYCLES      (4),
      .HOLD_CYCLES        (4),
      .PPS_TIMEOUT_CYCLES (100)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .req             (bus.slave),
      .pps_in          (pps_in),
      .time_strobe_sec (time_strobe_sec),
      .time_strobe_ns  (time_strobe_ns),
      .time_strobe     (time_strobe),
      .busy            (busy),
      .done            (done),
      .err_range       (err_range),
      .err_timeout     (err_timeout)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200_000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Presents one request; returns on the negedge right after the accepting posedge.
   task automatic send(input string tag, input logic [31:0] sec, input logic [31:0] ns,
                       input logic at_pps);
      for (int i = 0; i < 50 && !bus.s_ready; i++) @(negedge aclk);
      if (!bus.s_ready) check({tag, "_ready_wait"}, 64'(bus.s_ready), 64'd1);
      bus.s_sec    = sec;
      bus.s_ns     = ns;
      bus.s_at_pps = at_pps;
      bus.s_valid  = 1'b1;
      @(negedge aclk);
      bus.s_valid  = 1'b0;
      bus.s_sec    = 32'hDEAD_BEEF;
      bus.s_ns     = 32'h1234_5678;
   endtask

   // Samples outputs on n successive negedges (index 0 = first cycle after accept).
   task automatic trace(input int n, input int pps_at, input logic [31:0] exp_sec,
                        input logic [31:0] exp_ns, output int rise, output int high,
                        output int done_at, output int ready_at, output int tmo_at,
                        output int tmo_high, output int data_bad);
      rise = -1; high = 0; done_at = -1; ready_at = -1; tmo_at = -1; tmo_high = 0; data_bad = 0;
      for (int i = 0; i < n; i++) begin
         if (i >= 1 && (time_strobe_sec !== exp_sec || time_strobe_ns !== exp_ns)) data_bad++;
         if (time_strobe && rise < 0) rise = i;
         if (time_strobe) high++;
         if (done && done_at < 0) done_at = i;
         if (bus.s_ready && ready_at < 0) ready_at = i;
         if (err_timeout && tmo_at < 0) tmo_at = i;
         if (err_timeout) tmo_high++;
         if (i == pps_at) pps_in = 1'b1;
         @(negedge aclk);
      end
   endtask

   task automatic run_imm(input string tag, input logic [31:0] sec, input logic [31:0] ns,
                          input logic [31:0] exp_sec, input logic [31:0] exp_ns);
      int rise, high, done_at, ready_at, tmo_at, tmo_high, data_bad;
      send(tag, sec, ns, 1'b0);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      trace(16, -1, exp_sec, exp_ns, rise, high, done_at, ready_at, tmo_at, tmo_high, data_bad);
      check({tag, "_sec"}, 64'(time_strobe_sec), 64'(exp_sec));
      check({tag, "_ns"}, 64'(time_strobe_ns), 64'(exp_ns));
      check({tag, "_data_stable"}, 64'(data_bad), 64'd0);
      check({tag, "_rise_at"}, 64'(rise), 64'd5);
      check({tag, "_high_cycles"}, 64'(high), 64'd4);
      check({tag, "_done_at"}, 64'(done_at), 64'd12);
      check({tag, "_ready_at"}, 64'(ready_at), 64'd13);
   endtask

   initial begin
      int rise, high, done_at, ready_at, tmo_at, tmo_high, data_bad;
      bus.s_sec    = '0;
      bus.s_ns     = '0;
      bus.s_at_pps = 1'b0;
      bus.s_valid  = 1'b0;

      // Reset state
      repeat (2) @(negedge aclk);
      check("rst_ready", 64'(bus.s_ready), 64'd0);
      check("rst_outputs", {time_strobe_sec, time_strobe_ns}, 64'd0);
      check("rst_flags", 64'({time_strobe, busy, done, err_range, err_timeout}), 64'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_ready_after_edge", 64'(bus.s_ready), 64'd1);

      // Immediate path, carry, wrap and carry boundaries
      run_imm("imm", 32'd100, 32'd500_000_000, 32'd100, 32'd500_000_030);
      run_imm("carry", 32'd100, 32'd999_999_990, 32'd101, 32'd20);
      run_imm("no_carry_edge", 32'd5, 32'd999_999_969, 32'd5, 32'd999_999_999);
      run_imm("carry_edge", 32'd5, 32'd999_999_970, 32'd6, 32'd0);
      run_imm("wrap", 32'hFFFF_FFFF, 32'd999_999_980, 32'd0, 32'd10);

      // Range reject: outputs keep the wrap result
      send("range", 32'd42, 32'd1_000_000_000, 1'b0);
      check("range_err", 64'(err_range), 64'd1);
      check("range_ready", 64'(bus.s_ready), 64'd1);
      check("range_busy", 64'(busy), 64'd0);
      @(negedge aclk);
      check("range_err_pulse", 64'(err_range), 64'd0);
      check("range_no_strobe", 64'(time_strobe), 64'd0);
      check("range_outputs", {time_strobe_sec, time_strobe_ns}, {32'd0, 32'd10});

      // PPS aligned: s_ns ignored; ns = 20 latency + 30 compensation
      send("pps", 32'd7, 32'hFFFF_FFFF, 1'b1);
      check("pps_no_range_err", 64'(err_range), 64'd0);
      trace(20, 5, 32'd7, 32'd50, rise, high, done_at, ready_at, tmo_at, tmo_high, data_bad);
      pps_in = 1'b0;
      check("pps_sec_ns", {time_strobe_sec, time_strobe_ns}, {32'd7, 32'd50});
      check("pps_data_stable", 64'(data_bad), 64'd0);
      check("pps_rise_at", 64'(rise), 64'd9);
      check("pps_high_cycles", 64'(high), 64'd4);
      check("pps_done_at", 64'(done_at), 64'd16);
      check("pps_no_timeout", 64'(tmo_high), 64'd0);
      repeat (4) @(negedge aclk);

      // Timeout without PPS
      send("tmo", 32'd9, 32'd123, 1'b1);
      trace(110, -1, 32'd9, 32'd50, rise, high, done_at, ready_at, tmo_at, tmo_high, data_bad);
      check("tmo_at", 64'(tmo_at), 64'd101);
      check("tmo_pulse_width", 64'(tmo_high), 64'd1);
      check("tmo_no_strobe", 64'(high), 64'd0);
      check("tmo_ready_at", 64'(ready_at), 64'd101);
      check("tmo_idle", 64'(busy), 64'd0);

      // PPS edge lands on the timeout cycle: strobe wins
      send("coll", 32'd11, 32'd0, 1'b1);
      trace(115, 97, 32'd11, 32'd50, rise, high, done_at, ready_at, tmo_at, tmo_high, data_bad);
      pps_in = 1'b0;
      check("coll_rise_at", 64'(rise), 64'd101);
      check("coll_high_cycles", 64'(high), 64'd4);
      check("coll_no_timeout", 64'(tmo_high), 64'd0);
      check("coll_done_at", 64'(done_at), 64'd108);
      repeat (4) @(negedge aclk);

      // Asynchronous reset while the strobe is high
      send("rst_mid", 32'd200, 32'd5, 1'b0);
      repeat (6) @(negedge aclk);
      check("rst_mid_strobe_high", 64'(time_strobe), 64'd1);
      aresetn = 1'b0;
      #1;
      check("rst_mid_strobe", 64'(time_strobe), 64'd0);
      check("rst_mid_outputs", {time_strobe_sec, time_strobe_ns}, 64'd0);
      check("rst_mid_ready_busy", 64'({bus.s_ready, busy}), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_mid_ready_after", 64'(bus.s_ready), 64'd1);
      run_imm("after_rst", 32'd300, 32'd100, 32'd300, 32'd130);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
